mac_seq_ctrl: RTL
=================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter bw, default 4, operand width of a_in/b_in.
REQ-002 SHALL have parameter psum_bw, default 16, accumulator/result width.
REQ-003 SHALL have parameter len_bw, default 12, width of job length field.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  job launch request, sampled in IDLE only.
REQ-007 SHALL have port len  input  len_bw  number of (a,b) pairs in job, sampled with start.
REQ-008 SHALL have port abort  input  1  synchronous job cancel.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port in_valid  input  1  operand pair valid.
REQ-011 SHALL have port in_ready  output  1  controller accepts operand pair.
REQ-012 SHALL have port a_in  input  bw  activation, unsigned.
REQ-013 SHALL have port b_in  input  bw  weight, two's-complement signed.
REQ-014 SHALL have port out_valid  output  1  result valid.
REQ-015 SHALL have port out_ready  input  1  result consumer ready.
REQ-016 SHALL have port psum_out  output  psum_bw  accumulated dot product, two's complement.
REQ-017 SHALL have port ovf  output  1  sticky signed-overflow flag for current job, valid with out_valid.

Function
REQ-018 SHALL implement FSM states IDLE, ACC, DONE.
REQ-019 IDLE: start=1, len!=0 -> ACC next cycle; capture len, clear accumulator, counter, ovf.
REQ-020 IDLE: start=1, len=0 -> DONE next cycle, psum_out=0, ovf=0.
REQ-021 start outside IDLE SHALL be ignored, no effect on job.
REQ-022 in_ready SHALL be 1 only in ACC; handshake = in_valid & in_ready, one pair per cycle max.
REQ-023 Per accepted pair: acc <= acc + ({1'b0,a_in} signed * b_in signed), product sign-extended to psum_bw, sum wraps modulo 2^psum_bw.
REQ-024 ovf SHALL set when any accumulation step has signed overflow (operands same sign, result differs); remains set until next job start.
REQ-025 Pair counter SHALL increment per accepted pair; on acceptance of pair number len -> DONE next cycle.
REQ-026 in_valid low in ACC SHALL stall with acc and counter held; no timeout.
REQ-027 DONE: out_valid=1, psum_out=acc, ovf stable; held until out_ready=1.
REQ-028 DONE with out_ready=1 -> IDLE next cycle; out_valid low in IDLE.
REQ-029 Latency: out_valid SHALL rise the cycle after the last pair's handshake edge.
REQ-030 abort=1 in ACC or DONE -> IDLE next cycle, result discarded, no out_valid; abort has priority over handshakes same cycle; ignored in IDLE.
REQ-031 psum_out SHALL read 0 outside DONE.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, acc=0, counter=0, ovf=0, busy=0, in_ready=0, out_valid=0, psum_out=0, regardless of clk.
REQ-033 Reset asserted mid-job SHALL discard the job; no out_valid after release until new start.
REQ-034 First start honoured on first rising clk edge with reset_n high.

Verification
REQ-035 len=1, a=15, b=-8 -> out_valid one cycle after handshake, psum_out=0xFF88 (-120), ovf=0.
REQ-036 len=20, 20 pairs a=i (i=0..19, masked to 4 bits), b=3 constant, in_valid with random gaps -> psum_out equals bench model sum, accepted count exactly 20, in_ready low after 20th.
REQ-037 start with len=0 -> DONE next cycle, psum_out=0, no in_ready pulse.
REQ-038 len=400, a=15, b=7 every cycle -> psum_out=0xA410, ovf=1.
REQ-039 DONE with out_ready low 3 cycles then high -> out_valid/psum_out stable 4 cycles, IDLE after; start during DONE ignored.
REQ-040 reset_n low after 5 of 10 pairs, or abort same cycle as in_valid -> IDLE, outputs zero, no out_valid; fresh len=2 job afterward yields correct sum.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// Job control, operand stream and result stream of the MAC sequencer.
interface mac_seq_ctrl_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 12
) ();
  logic               start;
  logic [len_bw-1:0]  len;
  logic               abort;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [bw-1:0]      a_in;
  logic [bw-1:0]      b_in;
  logic               out_valid;
  logic               out_ready;
  logic [psum_bw-1:0] psum_out;
  logic               ovf;

  modport master (
    output start, len, abort, in_valid, a_in, b_in, out_ready,
    input  busy, in_ready, out_valid, psum_out, ovf
  );

  modport slave (
    input  start, len, abort, in_valid, a_in, b_in, out_ready,
    output busy, in_ready, out_valid, psum_out, ovf
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequenced multiply-accumulate: unsigned activations times signed weights
// over a job of len pairs, with sticky signed-overflow flag.
//
// state  | meaning
// S_IDLE | waiting for start; outputs quiet
// S_ACC  | accepting operand pairs, accumulating
// S_DONE | result presented until out_ready or abort
module mac_seq_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [psum_bw-1:0]  acc_q, acc_d;
  logic [len_bw-1:0]   cnt_q, cnt_d;
  logic [len_bw-1:0]   len_q, len_d;
  logic                ovf_q, ovf_d;

  logic [psum_bw-1:0]  a_ext, b_ext, prod, sum;
  logic                step_ovf;

  // Activation is zero-extended, weight sign-extended; the low psum_bw bits
  // of the product equal the sign-extended signed product.
  always_comb begin
    a_ext    = {{(psum_bw-bw){1'b0}}, bus.a_in};
    b_ext    = {{(psum_bw-bw){bus.b_in[bw-1]}}, bus.b_in};
    prod     = a_ext * b_ext;
    sum      = acc_q + prod;
    step_ovf = (acc_q[psum_bw-1] == prod[psum_bw-1]) &&
               (sum[psum_bw-1] != acc_q[psum_bw-1]);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d   = bus.len;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (bus.len == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.in_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | step_ovf;
          cnt_d = cnt_q + len_bw'(1);
          if (cnt_d == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.abort || bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.psum_out  = (state_q == S_DONE) ? acc_q : '0;
  assign bus.ovf       = (state_q == S_DONE) & ovf_q;

endmodule
